// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared constants and types for the LC-3 memory responder.
//   WORD_W        - bus word width
//   *_ADDR        - memory-mapped device register addresses
//   state_t       - responder FSM encoding
package mem_responder_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] IO_BASE   = 16'hFE00;
    localparam logic [WORD_W-1:0] KBSR_ADDR = 16'hFE00;
    localparam logic [WORD_W-1:0] KBDR_ADDR = 16'hFE02;
    localparam logic [WORD_W-1:0] DSR_ADDR  = 16'hFE04;
    localparam logic [WORD_W-1:0] DDR_ADDR  = 16'hFE06;
    localparam logic [WORD_W-1:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: LC-3 control-unit memory bus.
//   master - control unit: drives MEM_EN, MEM_W, MAR, MDR_in; sees MDR_out, R
//   slave  - memory responder: the reverse
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              MEM_EN;
    logic              MEM_W;
    logic [WORD_W-1:0] MAR;
    logic [WORD_W-1:0] MDR_in;
    logic [WORD_W-1:0] MDR_out;
    logic              R;

    modport master (output MEM_EN, MEM_W, MAR, MDR_in, input MDR_out, R);
    modport slave  (input MEM_EN, MEM_W, MAR, MDR_in, output MDR_out, R);
endinterface

// File: rtl/mem_io_regs.sv
// mem_io_regs: LC-3 device registers KBSR/KBDR/DSR/DDR/MCR.
//   acc/we/addr   - access strobe (RESP cycle), write flag, latched address
//   wr_run        - latched MDR_in[15] (MCR write value)
//   wr_byte       - latched MDR_in[7:0] (DDR write value)
//   rdata/hit     - device read data and "address is in device space"
//   kb_*          - keyboard valid/ready byte handshake (input side)
//   disp_*        - display valid/ready byte handshake (output side)
//   mcr_run       - MCR[15]
module mem_io_regs
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              acc,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic              wr_run,
    input  logic [7:0]        wr_byte,
    output logic [WORD_W-1:0] rdata,
    output logic              hit,
    input  logic [7:0]        kb_data,
    input  logic              kb_valid,
    output logic              kb_ready,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic              mcr_run
);

    logic       kb_full_q, kb_full_d;
    logic [7:0] kb_buf_q, kb_buf_d;
    logic       disp_busy_q, disp_busy_d;
    logic [7:0] disp_data_q, disp_data_d;
    logic       run_q, run_d;

    always_comb begin
        kb_full_d   = kb_full_q;
        kb_buf_d    = kb_buf_q;
        disp_busy_d = disp_busy_q;
        disp_data_d = disp_data_q;
        run_d       = run_q;

        // KBDR read empties the buffer; a capture is only possible when the
        // buffer was already empty, so the order here never loses a byte.
        if (acc && !we && addr == KBDR_ADDR) kb_full_d = 1'b0;
        if (kb_valid && !kb_full_q) begin
            kb_buf_d  = kb_data;
            kb_full_d = 1'b1;
        end

        // Handshake retires the old byte before a same-cycle DDR write is judged.
        if (disp_busy_q && disp_ready) disp_busy_d = 1'b0;
        if (acc && we && addr == DDR_ADDR && !disp_busy_d) begin
            disp_data_d = wr_byte;
            disp_busy_d = 1'b1;
        end

        if (acc && we && addr == MCR_ADDR) run_d = wr_run;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_full_q   <= 1'b0;
            kb_buf_q    <= '0;
            disp_busy_q <= 1'b0;
            disp_data_q <= '0;
            run_q       <= 1'b1;
        end else begin
            kb_full_q   <= kb_full_d;
            kb_buf_q    <= kb_buf_d;
            disp_busy_q <= disp_busy_d;
            disp_data_q <= disp_data_d;
            run_q       <= run_d;
        end
    end

    // Read mux uses current register state, so reads see pre-capture values.
    always_comb begin
        rdata = '0;
        case (addr)
            KBSR_ADDR: rdata = {kb_full_q, 15'b0};
            KBDR_ADDR: rdata = {8'b0, kb_buf_q};
            DSR_ADDR:  rdata = {~disp_busy_q, 15'b0};
            MCR_ADDR:  rdata = {run_q, 15'b0};
            default:   rdata = '0;
        endcase
    end

    assign hit        = (addr >= IO_BASE);
    assign kb_ready   = ~kb_full_q;
    assign disp_valid = disp_busy_q;
    assign disp_data  = disp_data_q;
    assign mcr_run    = run_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the LC-3 control-unit bus.
//   clk, reset  - clock, asynchronous active-low reset
//   bus         - MEM_EN/MEM_W/MAR/MDR_in requests, MDR_out/R responses
//   kb_*        - keyboard byte handshake
//   disp_*      - display byte handshake
//   mcr_run     - MCR[15] CPU clock enable
// Requests are latched in IDLE, held WAIT_CYCLES cycles, and serviced in RESP,
// where R is high and MDR_out carries the read data.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 4096
)(
    input  logic       clk,
    input  logic       reset,
    mem_responder_if.slave bus,
    input  logic [7:0] kb_data,
    input  logic       kb_valid,
    output logic       kb_ready,
    output logic [7:0] disp_data,
    output logic       disp_valid,
    input  logic       disp_ready,
    output logic       mcr_run
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WORD_W-1:0] DEPTH_W  = WORD_W'(MEM_DEPTH);
    localparam logic [CW-1:0]     CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] mdr_q, mdr_d;

    logic [WORD_W-1:0] ram [MEM_DEPTH];
    logic [WORD_W-1:0] ram_rd_q;
    logic [WORD_W-1:0] io_rdata, rd_data;
    logic              io_hit, ram_hit, resp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (bus.MEM_EN) begin
                addr_d  = bus.MAR;
                we_d    = bus.MEM_W;
                wdata_d = bus.MDR_in;
                cnt_d   = CNT_LOAD;
                state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp    = (state_q == RESP);
    assign ram_hit = (addr_q < DEPTH_W);
    assign rd_data = io_hit ? io_rdata : (ram_hit ? ram_rd_q : '0);

    // MDR_out is live during the R cycle on reads, otherwise the held value.
    assign mdr_d       = (resp && !we_q) ? rd_data : mdr_q;
    assign bus.MDR_out = mdr_d;
    assign bus.R       = resp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
        end
    end

    // The synchronous read is launched on the edge entering RESP so the word
    // is on MDR_out during the R cycle. Writes commit at the end of RESP and
    // are suppressed while reset is asserted so a dropped access never lands.
    always_ff @(posedge clk) begin
        if (state_d == RESP && addr_d < DEPTH_W)
            ram_rd_q <= ram[addr_d[AW-1:0]];
        if (resp && we_q && ram_hit && reset)
            ram[addr_q[AW-1:0]] <= wdata_q;
    end

    mem_io_regs u_io (
        .clk        (clk),
        .reset      (reset),
        .acc        (resp),
        .we         (we_q),
        .addr       (addr_q),
        .wr_run     (wdata_q[15]),
        .wr_byte    (wdata_q[7:0]),
        .rdata      (io_rdata),
        .hit        (io_hit),
        .kb_data    (kb_data),
        .kb_valid   (kb_valid),
        .kb_ready   (kb_ready),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .mcr_run    (mcr_run)
    );

endmodule
